uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_parity_calc.sv | 15 +
 rtl/uart_tx_serializer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive paths: FSM encoding,
// parity type and line levels, plus a width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter widths never collapse to zero bits, even for a range of one.
    function automatic int unsigned min1_clog2(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit generator shared by TX and RX so both ends agree bit-for-bit.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    // Even parity makes the total count of ones even; odd inverts that bit.
    assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a word on DATA_VALID and shifts out start, data
// (LSB first), optional parity and stop bits, each held CLKS_PER_BIT cycles.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned CNT_W = min1_clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = min1_clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shadow_data_q;
    logic shadow_par_en_q;
    logic shadow_par_typ_q;
    logic latch_en;
    logic bit_done;
    logic parity_bit;
    logic tx_d;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (shadow_data_q),
        .par_typ(shadow_par_typ_q),
        .parity (parity_bit)
    );

    assign bit_done = (cnt_q == LAST_CNT);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        latch_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (DATA_VALID) begin
                    latch_en = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = shadow_par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Line level is decoded from the next state so the output flop
        // changes on the same edge as the state register.
        case (state_d)
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shadow_data_q[idx_d];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = STOP_BIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            TX_OUT  <= STOP_BIT;
            Busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            TX_OUT  <= tx_d;
            Busy    <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_q    <= '0;
            shadow_par_en_q  <= 1'b0;
            shadow_par_typ_q <= PAR_EVEN;
        end else if (latch_en) begin
            shadow_data_q    <= P_DATA;
            shadow_par_en_q  <= PAR_EN;
            shadow_par_typ_q <= PAR_TYP;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 16 clocks per bit) share
// stimulus and are compared every cycle against a queue-based line model.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx1, busy1, tx16, busy16;

    int n_checks = 0;
    int n_fail = 0;
    int busy1_cnt = 0;
    int busy16_cnt = 0;
    bit mon_en = 1'b0;

    // Expected line level for each upcoming cycle; empty means idle.
    logic q1[$];
    logic q16[$];
    bit   acc1, acc16;
    int   frame_len;
    logic fbit;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .P_DATA(p_data), .DATA_VALID(data_valid),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx1), .Busy(busy1)
    );

    uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .P_DATA(p_data), .DATA_VALID(data_valid),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx16), .Busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit at position pos of a frame: start, 8 data LSB first, parity?, stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic pen,
                                       input logic ptyp, input int pos);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[pos-1];
        if (pos == 9 && pen) return ptyp ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
            q16.delete();
        end else begin
            acc1  = (q1.size() == 0) && data_valid;
            acc16 = (q16.size() == 0) && data_valid;
            if (q1.size() > 0) void'(q1.pop_front());
            if (q16.size() > 0) void'(q16.pop_front());
            frame_len = 10 + int'(par_en);
            for (int pos = 0; pos < frame_len; pos++) begin
                fbit = frame_bit(p_data, par_en, par_typ, pos);
                if (acc1) q1.push_back(fbit);
                if (acc16) for (int r = 0; r < 16; r++) q16.push_back(fbit);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("tx_c1", tx1, (q1.size() > 0) ? q1[0] : 1'b1);
            check("busy_c1", busy1, q1.size() > 0);
            check("tx_c16", tx16, (q16.size() > 0) ? q16[0] : 1'b1);
            check("busy_c16", busy16, q16.size() > 0);
        end
    end

    // Drive one cycle's inputs, then advance to the middle of the next cycle.
    task automatic cycle(input logic dv, input logic [7:0] d, input logic pen, input logic pt);
        data_valid = dv;
        p_data     = d;
        par_en     = pen;
        par_typ    = pt;
        @(negedge clk);
        busy1_cnt  += int'(busy1);
        busy16_cnt += int'(busy16);
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic pt);
        busy1_cnt  = 0;
        busy16_cnt = 0;
        cycle(1'b1, d, pen, pt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_c1", tx1, 1'b1);
        check("rst_busy_c1", busy1, 1'b0);
        check("rst_tx_c16", tx16, 1'b1);
        check("rst_busy_c16", busy16, 1'b0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        idle(3);

        send(8'hA5, 1'b0, 1'b0);
        idle(19);
        check("busy_len_nopar", busy1_cnt, 10);
        idle(150);

        send(8'hA5, 1'b1, 1'b0);
        idle(19);
        check("busy_len_even", busy1_cnt, 11);
        idle(160);

        send(8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 19; i++) cycle(1'b0, 8'hFF, 1'b0, 1'b0);
        check("busy_len_odd", busy1_cnt, 11);
        idle(160);

        // Strobes mid-frame and on the final stop cycle are dropped; the next
        // one, on the first idle cycle, starts a new frame.
        send(8'h3C, 1'b0, 1'b0);
        idle(4);
        cycle(1'b1, 8'($urandom), 1'b1, 1'b1);
        idle(4);
        cycle(1'b1, 8'($urandom), 1'b1, 1'b1);
        send(8'hC3, 1'b0, 1'b0);
        idle(19);
        check("busy_len_b2b", busy1_cnt, 10);
        idle(160);

        send(8'h80, 1'b0, 1'b0);
        idle(169);
        check("busy_len_baud16", busy16_cnt, 160);
        idle(5);

        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 7) == 0, 8'($urandom), 1'($urandom), 1'($urandom));
        idle(180);

        // Abort a frame while data bit 3 (a zero) is on the line.
        send(8'hF7, 1'b0, 1'b0);
        idle(4);
        check("pre_rst_bit3_c1", tx1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx_c1", tx1, 1'b1);
        check("async_rst_busy_c1", busy1, 1'b0);
        check("async_rst_tx_c16", tx16, 1'b1);
        check("async_rst_busy_c16", busy16, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        busy1_cnt  = 0;
        busy16_cnt = 0;
        idle(40);
        check("post_rst_busy_c1", busy1_cnt, 0);
        check("post_rst_busy_c16", busy16_cnt, 0);

        send(8'h5A, 1'b1, 1'b1);
        idle(180);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
